instr_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 22 ++
 rtl/instr_sequencer_if.sv | 41 ++++
 rtl/instr_sequencer_seq_pc.sv | 35 +++
 rtl/instr_sequencer.sv | 152 +++++++++++++++
 tb/tb_instr_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, instruction-register field positions and opcodes.
// Latency: none (constants and pure helper functions only).
// Backpressure: not applicable.
package cpu_pkg;
    localparam int DW    = 9;
    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int RX_HI = 5;
    localparam int RX_LO = 3;
    localparam int RY_HI = 2;
    localparam int RY_LO = 0;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // True when the opcode field says the next program word is an immediate.
    function automatic logic op_is_mvi(input logic [2:0] op);
        return op == OP_MVI;
    endfunction
endpackage

// File: rtl/instr_sequencer_if.sv
// Bundle between the instruction sequencer, its program ROM, the CPU and the run controller.
// Latency: wires only. SEQ_SINGLE_STEP_EN adds the iStep request line.
// Backpressure: iIrLd/iDone from the CPU pace the sequencer; the ROM is never stalled.
interface instr_sequencer_if #(
    parameter int AW = 8,
    parameter int DW = 9
);
    logic          iStart;
    logic          iStop;
    logic [AW-1:0] iStartAddr;
    logic [AW-1:0] iEndAddr;
    logic          oRdEn;
    logic [AW-1:0] oAddr;
    logic [DW-1:0] iRdata;
    logic [DW-1:0] oDin;
    logic          oRun;
    logic          iIrLd;
    logic          iDone;
    logic          oBusy;
    logic          oHalted;
    logic [AW-1:0] oPc;
`ifdef SEQ_SINGLE_STEP_EN
    logic          iStep;
`endif

    modport master (
`ifdef SEQ_SINGLE_STEP_EN
        input  iStep,
`endif
        input  iStart, iStop, iStartAddr, iEndAddr, iRdata, iIrLd, iDone,
        output oRdEn, oAddr, oDin, oRun, oBusy, oHalted, oPc
    );

    modport slave (
`ifdef SEQ_SINGLE_STEP_EN
        output iStep,
`endif
        output iStart, iStop, iStartAddr, iEndAddr, iRdata, iIrLd, iDone,
        input  oRdEn, oAddr, oDin, oRun, oBusy, oHalted, oPc
    );
endinterface

// File: rtl/instr_sequencer_seq_pc.sv
// Program counter: load, +1/+2 advance, carry-out and end-of-program compare.
// Latency: pc updates on the clock edge; pc_plus1/past_end are combinational from pc.
// Backpressure: none; load and advance are single-cycle commands from the sequencer.
module seq_pc #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          advance,
    input  logic          step2,
    input  logic [AW-1:0] end_addr,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_plus1,
    output logic          past_end
);
    logic [AW:0] sum;

    // One extra bit keeps the carry so a wrap past the top of memory reads as "past the end".
    assign sum      = {1'b0, pc} + {{(AW-1){1'b0}}, step2, ~step2};
    assign pc_plus1 = pc + AW'(1);
    assign past_end = sum[AW] | (sum[AW-1:0] > end_addr);

    // PC register: start address load wins over advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (advance) begin
            pc <= sum[AW-1:0];
        end
    end
endmodule

// File: rtl/instr_sequencer.sv
// Program-issue engine: fetches words from a sync ROM and drives CPU Run/DIN (MVI immediates too).
// Latency: Run rises 2 cycles after FETCH (3 for MVI); one Run-low GAP cycle between instructions.
// Backpressure: holds Run/DIN until the CPU strobes iIrLd then iDone. SEQ_SINGLE_STEP_EN adds a STEP wait.
module instr_sequencer #(
    parameter int AW = 8,
    parameter int DW = 9
) (
    input  logic              iClk,
    input  logic              iRst_n,
    instr_sequencer_if.master bus
);
    import cpu_pkg::*;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_FWAIT, S_IMMW, S_ISSUE, S_EXEC, S_GAP, S_HALTED
`ifdef SEQ_SINGLE_STEP_EN
        , S_STEP
`endif
    } state_t;

    state_t        state;
    logic [DW-1:0] instr;
    logic [DW-1:0] imm;
    logic [DW-1:0] din;
    logic          run;
    logic          busy;
    logic          halted;
    logic          stop_pend;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_plus1;
    logic          past_end;
    logic          start_ok;
    logic          halt_now;
    logic          gap_cont;
    logic          instr_mvi;
    logic          rdata_mvi;

    assign instr_mvi = op_is_mvi(instr[OP_HI:OP_LO]);
    assign rdata_mvi = op_is_mvi(bus.iRdata[OP_HI:OP_LO]);
    assign start_ok  = ((state == S_IDLE) || (state == S_HALTED)) && bus.iStart;
    assign halt_now  = stop_pend || bus.iStop || past_end;
    // The PC only moves when another instruction follows, so a halted
    // sequencer keeps reporting the address of the last executed instruction.
    assign gap_cont  = (state == S_GAP) && !halt_now;

    seq_pc #(.AW(AW)) u_pc (
        .clk      (iClk),
        .rst_n    (iRst_n),
        .load     (start_ok),
        .load_val (bus.iStartAddr),
        .advance  (gap_cont),
        .step2    (instr_mvi),
        .end_addr (bus.iEndAddr),
        .pc       (pc),
        .pc_plus1 (pc_plus1),
        .past_end (past_end)
    );

    // The immediate read has to go out in the same cycle the opcode word arrives,
    // otherwise MVI would need an extra wait state, so the read strobe decodes iRdata.
    assign bus.oRdEn   = (state == S_FETCH) || ((state == S_FWAIT) && rdata_mvi);
    assign bus.oAddr   = (state == S_FWAIT) ? pc_plus1 : pc;
    assign bus.oDin    = din;
    assign bus.oRun    = run;
    assign bus.oBusy   = busy;
    assign bus.oHalted = halted;
    assign bus.oPc     = pc;

    // Sequencer FSM with registered Run/DIN/status; reset aborts any instruction at once.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= S_IDLE;
            instr     <= '0;
            imm       <= '0;
            din       <= '0;
            run       <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            if (bus.iStop && busy) begin
                stop_pend <= 1'b1;
            end
            case (state)
                S_IDLE, S_HALTED: begin
                    if (bus.iStart) begin
                        state  <= S_FETCH;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                S_FETCH: state <= S_FWAIT;
                S_FWAIT: begin
                    instr <= bus.iRdata;
                    if (rdata_mvi) begin
                        state <= S_IMMW;
                    end else begin
                        state <= S_ISSUE;
                        run   <= 1'b1;
                        din   <= bus.iRdata;
                    end
                end
                S_IMMW: begin
                    imm   <= bus.iRdata;
                    state <= S_ISSUE;
                    run   <= 1'b1;
                    din   <= instr;
                end
                S_ISSUE: begin
                    // The opcode word stays on DIN through the IR-load cycle itself.
                    if (bus.iIrLd) begin
                        state <= S_EXEC;
                        din   <= instr_mvi ? imm : instr;
                    end
                end
                S_EXEC: begin
                    if (bus.iDone) begin
                        state <= S_GAP;
                        run   <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (halt_now) begin
                        state     <= S_HALTED;
                        busy      <= 1'b0;
                        halted    <= 1'b1;
                        stop_pend <= 1'b0;
                    end else begin
`ifdef SEQ_SINGLE_STEP_EN
                        state <= S_STEP;
`else
                        state <= S_FETCH;
`endif
                    end
                end
`ifdef SEQ_SINGLE_STEP_EN
                S_STEP: begin
                    if (stop_pend || bus.iStop) begin
                        state     <= S_HALTED;
                        busy      <= 1'b0;
                        halted    <= 1'b1;
                        stop_pend <= 1'b0;
                    end else if (bus.iStep) begin
                        state <= S_FETCH;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: sync ROM model, CPU handshake model and an issue scoreboard.
// Latency: expectations are per program run (issued words, final PC, ROM read trace).
// Backpressure: the CPU model answers Run with iIrLd after 2 cycles and iDone 1 cycle later.
module tb_instr_sequencer;
    import cpu_pkg::*;

    typedef struct packed {
        logic [8:0] ir;
        logic [8:0] ex;
        logic [7:0] pc;
    } sb_t;

    typedef struct packed {
        logic [7:0]      start_a;
        logic [7:0]      end_a;
        logic [1:0]      n_issue;
        logic [2:0][8:0] ir;
        logic [2:0][8:0] ex;
        logic [2:0][7:0] ipc;
        logic [7:0]      fin_pc;
        logic [1:0]      n_rd;
        logic [2:0][7:0] rd;
        logic            patch;
        logic [7:0]      patch_a;
        logic [8:0]      patch_w;
    } vec_t;

    logic       iClk;
    logic       iRst_n;
    logic [8:0] rom [256];
    sb_t        sb_q [$];
    logic [7:0] rd_log [$];
    bit         sb_hold;
    int         checks;
    int         errors;
    vec_t       vt [8];

    instr_sequencer_if #(.AW(8), .DW(9)) bus ();

    instr_sequencer #(.AW(8), .DW(9)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Synchronous program ROM: data one cycle after the read strobe.
    always @(posedge iClk) begin
        if (bus.oRdEn) bus.iRdata <= rom[bus.oAddr];
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ROM read trace.
    initial begin
        forever begin
            @(negedge iClk);
            if (bus.oRdEn === 1'b1) rd_log.push_back(bus.oAddr);
        end
    end

    // CPU model and scoreboard consumer.
    initial begin : cpu_model
        sb_t        e;
        logic [8:0] d1, d2, d3;
        logic [7:0] p2;
        logic       r4;
        bus.iIrLd = 1'b0;
        bus.iDone = 1'b0;
        forever begin
            @(negedge iClk);
            if (bus.oRun === 1'b1) begin
                @(negedge iClk); d1 = bus.oDin;
                @(negedge iClk); bus.iIrLd = 1'b1; d2 = bus.oDin; p2 = bus.oPc;
                @(negedge iClk); bus.iIrLd = 1'b0; bus.iDone = 1'b1; d3 = bus.oDin;
                @(negedge iClk); bus.iDone = 1'b0; r4 = bus.oRun;
                if (!sb_hold) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: unexpected instruction, din %0h pc %0h", d2, p2);
                    end else begin
                        e = sb_q.pop_front();
                        chk("din_issue", {23'd0, d1}, {23'd0, e.ir});
                        chk("din_irld", {23'd0, d2}, {23'd0, e.ir});
                        chk("din_exec", {23'd0, d3}, {23'd0, e.ex});
                        chk("pc_issue", {24'd0, p2}, {24'd0, e.pc});
                        chk("run_after_done", {31'd0, r4}, 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [7:0] s, input logic [7:0] en, input int n,
                                input logic [8:0] ir0, input logic [8:0] ex0, input logic [7:0] p0,
                                input logic [8:0] ir1, input logic [8:0] ex1, input logic [7:0] p1,
                                input logic [8:0] ir2, input logic [8:0] ex2, input logic [7:0] p2,
                                input logic [7:0] fpc, input int nrd,
                                input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                                input logic pt, input logic [7:0] pa, input logic [8:0] pw);
        vec_t v;
        v.start_a = s;   v.end_a = en;   v.n_issue = 2'(n);
        v.ir[0] = ir0;   v.ex[0] = ex0;  v.ipc[0] = p0;
        v.ir[1] = ir1;   v.ex[1] = ex1;  v.ipc[1] = p1;
        v.ir[2] = ir2;   v.ex[2] = ex2;  v.ipc[2] = p2;
        v.fin_pc = fpc;  v.n_rd = 2'(nrd);
        v.rd[0] = r0;    v.rd[1] = r1;   v.rd[2] = r2;
        v.patch = pt;    v.patch_a = pa; v.patch_w = pw;
        return v;
    endfunction

    task automatic pulse_start();
        @(negedge iClk); bus.iStart = 1'b1;
        @(negedge iClk); bus.iStart = 1'b0;
    endtask

    task automatic wait_halt(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge iClk);
            if (bus.oHalted === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_run(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge iClk);
            if (bus.oRun === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  base;
        bit  ok;
        sb_t e;
        if (v.patch) rom[v.patch_a] = v.patch_w;
        bus.iStartAddr = v.start_a;
        bus.iEndAddr   = v.end_a;
        for (int i = 0; i < int'(v.n_issue); i++) begin
            e.ir = v.ir[i]; e.ex = v.ex[i]; e.pc = v.ipc[i];
            sb_q.push_back(e);
        end
        base = rd_log.size();
        pulse_start();
        wait_halt(300, ok);
        chk($sformatf("v%0d_halted", idx), {31'd0, bus.oHalted}, 32'd1);
        chk($sformatf("v%0d_busy", idx), {31'd0, bus.oBusy}, 32'd0);
        chk($sformatf("v%0d_pc", idx), {24'd0, bus.oPc}, {24'd0, v.fin_pc});
        chk($sformatf("v%0d_sb_left", idx), sb_q.size(), 32'd0);
        chk($sformatf("v%0d_nreads", idx), rd_log.size() - base, {30'd0, v.n_rd});
        for (int i = 0; i < int'(v.n_rd); i++) begin
            if (base + i < rd_log.size())
                chk($sformatf("v%0d_rd%0d", idx, i), {24'd0, rd_log[base + i]}, {24'd0, v.rd[i]});
        end
        sb_q.delete();
    endtask

    task automatic lat_test(input logic [7:0] s, input bit mvi, input logic [8:0] ir, input logic [8:0] ex);
        bit  ok;
        sb_t e;
        bus.iStartAddr = s;
        bus.iEndAddr   = s;
        e.ir = ir; e.ex = ex; e.pc = s;
        sb_q.push_back(e);
        pulse_start();
        chk("lat_fetch_rden", {31'd0, bus.oRdEn}, 32'd1);
        chk("lat_fetch_addr", {24'd0, bus.oAddr}, {24'd0, s});
        chk("lat_fetch_busy", {31'd0, bus.oBusy}, 32'd1);
        chk("lat_fetch_run", {31'd0, bus.oRun}, 32'd0);
        @(negedge iClk);
        chk("lat_fwait_rden", {31'd0, bus.oRdEn}, {31'd0, mvi});
        chk("lat_fwait_run", {31'd0, bus.oRun}, 32'd0);
        if (mvi) begin
            chk("lat_imm_addr", {24'd0, bus.oAddr}, {24'd0, 8'(s + 8'd1)});
            @(negedge iClk);
            chk("lat_immw_run", {31'd0, bus.oRun}, 32'd0);
        end
        @(negedge iClk);
        chk("lat_issue_run", {31'd0, bus.oRun}, 32'd1);
        chk("lat_issue_din", {23'd0, bus.oDin}, {23'd0, ir});
        wait_halt(100, ok);
        chk("lat_halted", {31'd0, bus.oHalted}, 32'd1);
        chk("lat_pc", {24'd0, bus.oPc}, {24'd0, s});
        sb_q.delete();
    endtask

    initial begin : main
        bit ok;
        int base;
        checks  = 0;
        errors  = 0;
        sb_hold = 1'b0;
        for (int a = 0; a < 256; a++) rom[a] = 9'h000;
        rom[0] = {OP_ADD, 3'd1, 3'd2};
        rom[1] = {OP_SUB, 3'd3, 3'd4};
        rom[2] = {OP_MV,  3'd1, 3'd2};
        rom[3] = 9'o777;
        rom[4] = {OP_MVI, 3'd3, 3'd0};
        rom[5] = 9'h0A5;
        rom[6] = {OP_MV,  3'd5, 3'd6};

        vt[0] = mk(8'd2, 8'd2, 1, 9'o012, 9'o012, 8'd2, 9'd0, 9'd0, 8'd0, 9'd0, 9'd0, 8'd0,
                   8'd2, 1, 8'd2, 8'd0, 8'd0, 1'b0, 8'd0, 9'd0);
        vt[1] = mk(8'd0, 8'd2, 3, 9'o212, 9'o212, 8'd0, 9'o334, 9'o334, 8'd1, 9'o012, 9'o012, 8'd2,
                   8'd2, 3, 8'd0, 8'd1, 8'd2, 1'b0, 8'd0, 9'd0);
        vt[2] = mk(8'd4, 8'd6, 2, 9'o130, 9'h0A5, 8'd4, 9'o056, 9'o056, 8'd6, 9'd0, 9'd0, 8'd0,
                   8'd6, 3, 8'd4, 8'd5, 8'd6, 1'b0, 8'd0, 9'd0);
        vt[3] = mk(8'd4, 8'd4, 1, 9'o130, 9'h0A5, 8'd4, 9'd0, 9'd0, 8'd0, 9'd0, 9'd0, 8'd0,
                   8'd4, 2, 8'd4, 8'd5, 8'd0, 1'b0, 8'd0, 9'd0);
        vt[4] = mk(8'd1, 8'd1, 1, 9'o334, 9'o334, 8'd1, 9'd0, 9'd0, 8'd0, 9'd0, 9'd0, 8'd0,
                   8'd1, 1, 8'd1, 8'd0, 8'd0, 1'b0, 8'd0, 9'd0);
        vt[5] = mk(8'd3, 8'd3, 1, 9'o777, 9'o777, 8'd3, 9'd0, 9'd0, 8'd0, 9'd0, 9'd0, 8'd0,
                   8'd3, 1, 8'd3, 8'd0, 8'd0, 1'b0, 8'd0, 9'd0);
        vt[6] = mk(8'd255, 8'd255, 1, 9'o070, 9'o070, 8'd255, 9'd0, 9'd0, 8'd0, 9'd0, 9'd0, 8'd0,
                   8'd255, 1, 8'd255, 8'd0, 8'd0, 1'b1, 8'd255, 9'o070);
        vt[7] = mk(8'd255, 8'd255, 1, 9'o170, 9'o212, 8'd255, 9'd0, 9'd0, 8'd0, 9'd0, 9'd0, 8'd0,
                   8'd255, 2, 8'd255, 8'd0, 8'd0, 1'b1, 8'd255, 9'o170);

        iRst_n         = 1'b0;
        bus.iStart     = 1'b0;
        bus.iStop      = 1'b0;
        bus.iStartAddr = 8'd0;
        bus.iEndAddr   = 8'd0;
        bus.iRdata     = 9'd0;
`ifdef SEQ_SINGLE_STEP_EN
        bus.iStep      = 1'b1;
`endif
        repeat (3) @(negedge iClk);
        chk("rst_run", {31'd0, bus.oRun}, 32'd0);
        chk("rst_busy", {31'd0, bus.oBusy}, 32'd0);
        chk("rst_halted", {31'd0, bus.oHalted}, 32'd0);
        chk("rst_rden", {31'd0, bus.oRdEn}, 32'd0);
        chk("rst_pc", {24'd0, bus.oPc}, 32'd0);
        chk("rst_din", {23'd0, bus.oDin}, 32'd0);
        iRst_n = 1'b1;
        @(negedge iClk);
        bus.iStop = 1'b1;
        @(negedge iClk);
        bus.iStop = 1'b0;
        repeat (2) @(negedge iClk);
        chk("idle_busy", {31'd0, bus.oBusy}, 32'd0);
        chk("idle_halted", {31'd0, bus.oHalted}, 32'd0);

        lat_test(8'd2, 1'b0, 9'o012, 9'o012);
        lat_test(8'd4, 1'b1, 9'o130, 9'h0A5);

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Stop during EXEC of the first of three instructions.
        bus.iStartAddr = 8'd0;
        bus.iEndAddr   = 8'd2;
        sb_q.push_back(sb_t'{ir: 9'o212, ex: 9'o212, pc: 8'd0});
        base = rd_log.size();
        pulse_start();
        wait_run(50, ok);
        chk("stop_run_seen", {31'd0, ok}, 32'd1);
        @(negedge iClk);
        @(negedge iClk);
        @(negedge iClk); bus.iStop = 1'b1;
        @(negedge iClk); bus.iStop = 1'b0;
        wait_halt(50, ok);
        chk("stop_halted", {31'd0, bus.oHalted}, 32'd1);
        chk("stop_pc", {24'd0, bus.oPc}, 32'd0);
        repeat (6) @(negedge iClk);
        chk("stop_nreads", rd_log.size() - base, 32'd1);
        chk("stop_sb_left", sb_q.size(), 32'd0);
        chk("stop_still_halted", {31'd0, bus.oHalted}, 32'd1);
        sb_q.delete();
        run_vec(vt[1], 100);

        // Reset between clock edges in the middle of EXEC.
        sb_hold = 1'b1;
        bus.iStartAddr = 8'd0;
        bus.iEndAddr   = 8'd2;
        pulse_start();
        wait_run(50, ok);
        chk("arst_run_seen", {31'd0, ok}, 32'd1);
        @(negedge iClk);
        @(negedge iClk);
        @(negedge iClk);
        #2 iRst_n = 1'b0;
        #1;
        chk("arst_run", {31'd0, bus.oRun}, 32'd0);
        chk("arst_busy", {31'd0, bus.oBusy}, 32'd0);
        chk("arst_rden", {31'd0, bus.oRdEn}, 32'd0);
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        base = rd_log.size();
        repeat (6) @(negedge iClk);
        chk("post_rst_busy", {31'd0, bus.oBusy}, 32'd0);
        chk("post_rst_halted", {31'd0, bus.oHalted}, 32'd0);
        chk("post_rst_pc", {24'd0, bus.oPc}, 32'd0);
        chk("post_rst_reads", rd_log.size() - base, 32'd0);
        chk("post_rst_run", {31'd0, bus.oRun}, 32'd0);
        sb_hold = 1'b0;
        run_vec(vt[4], 101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
